// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the datapath top level and the MULTU/DIVU sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic             divByZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller that borrows the single-cycle ALU for one
// add (multiply) or subtract (restoring divide) per cycle over WIDTH iterations,
// accumulating the 2*WIDTH-bit result in HI/LO.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetN,
  muldiv_sequencer_if.slave bus,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [2:0]       aluControl,
  input  logic [WIDTH-1:0] aluResult
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [2:0]     ALU_ADD = 3'b010;
  localparam logic [2:0]     ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic             opDiv;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hiR;
  logic [WIDTH-1:0] loR;
  logic             busyR;
  logic             doneR;
  logic             dbzR;

  // Divide step operand: partial remainder shifted left with the next dividend bit;
  // the bit shifted out of HI means the true remainder already exceeds the divisor.
  logic [WIDTH-1:0] r;
  logic             outBit;
  logic             carry;
  logic             borrow;

  assign bus.busy      = busyR;
  assign bus.done      = doneR;
  assign bus.divByZero = dbzR;
  assign bus.hi        = hiR;
  assign bus.lo        = loR;

  // ALU operand steering and local carry/borrow recovery from the ALU sum
  always_comb begin
    r          = {hiR[WIDTH-2:0], loR[WIDTH-1]};
    outBit     = hiR[WIDTH-1];
    carry      = (aluResult < hiR);
    borrow     = (aluResult > r);
    aluA       = '0;
    aluB       = '0;
    aluControl = ALU_ADD;
    if (state == RUN) begin
      if (opDiv) begin
        aluA       = r;
        aluB       = m;
        aluControl = ALU_SUB;
      end else begin
        aluA       = hiR;
        aluB       = m;
        aluControl = ALU_ADD;
      end
    end
  end

  // Sequencer FSM with registered status and HI/LO accumulation
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      opDiv <= 1'b0;
      m     <= '0;
      count <= '0;
      hiR   <= '0;
      loR   <= '0;
      busyR <= 1'b0;
      doneR <= 1'b0;
      dbzR  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneR <= 1'b0;
          if (bus.start) begin
            opDiv <= bus.op;
            m     <= bus.srcB;
            count <= '0;
            busyR <= 1'b1;
            if (bus.op && (bus.srcB == '0)) begin
              hiR   <= bus.srcA;
              loR   <= '1;
              dbzR  <= 1'b1;
              doneR <= 1'b1;
              state <= DONE;
            end else begin
              hiR   <= '0;
              loR   <= bus.srcA;
              dbzR  <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (opDiv) begin
            if (outBit || !borrow) begin
              hiR <= aluResult;
              loR <= {loR[WIDTH-2:0], 1'b1};
            end else begin
              hiR <= r;
              loR <= {loR[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (loR[0]) begin
              hiR <= {carry, aluResult[WIDTH-1:1]};
              loR <= {aluResult[0], loR[WIDTH-1:1]};
            end else begin
              hiR <= {1'b0, hiR[WIDTH-1:1]};
              loR <= {hiR[0], loR[WIDTH-1:1]};
            end
          end
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            doneR <= 1'b1;
          end
        end
        DONE: begin
          doneR <= 1'b0;
          busyR <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busyR <= 1'b0;
          doneR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random
// MULTU/DIVU operations compared against plain 64-bit arithmetic.
module tb_muldiv_sequencer;

  logic        clk;
  logic        resetN;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [2:0]  aluControl;
  logic [31:0] aluResult;

  int unsigned vectors;
  int unsigned miscompares;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .bus        (bus.slave),
    .aluA       (aluA),
    .aluB       (aluB),
    .aluControl (aluControl),
    .aluResult  (aluResult)
  );

  // The shared single-cycle ALU
  assign aluResult = (aluControl == 3'b110) ? (aluA - aluB) : (aluA + aluB);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for done starting at cycle index t0 (called at a negedge), then checks
  // latency, result and return to idle. Ends at the negedge of the first IDLE cycle.
  task automatic finish_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                           input int t0, input bit hold);
    int          t;
    bit          seen;
    logic [63:0] prod;
    logic [31:0] eh, el;
    logic        ed;
    int          expCycle;
    seen = 1'b0;
    t    = t0;
    while (!seen && t <= 40) begin
      check("busy_run", bus.busy, 1);
      if (bus.done) begin
        seen = 1'b1;
        if (!hold) bus.start = 1'b0;
      end else begin
        if (!hold) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.op    = 1'($urandom_range(0, 1));
          bus.srcA  = $urandom;
          bus.srcB  = $urandom;
        end
        @(negedge clk);
        t++;
      end
    end
    if (o && b == 32'd0) begin
      eh = a; el = 32'hFFFFFFFF; ed = 1'b1; expCycle = 1;
    end else if (o) begin
      eh = a % b; el = a / b; ed = 1'b0; expCycle = 33;
    end else begin
      prod = 64'(a) * 64'(b);
      eh = prod[63:32]; el = prod[31:0]; ed = 1'b0; expCycle = 33;
    end
    check("done_cycle", 64'(t), 64'(expCycle));
    check("hi", bus.hi, eh);
    check("lo", bus.lo, el);
    check("divByZero", bus.divByZero, ed);
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_hi_hold", bus.hi, eh);
    check("idle_lo_hold", bus.lo, el);
  endtask

  task automatic do_op(input bit o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    bus.start = 1'b1;
    bus.op    = o;
    bus.srcA  = a;
    bus.srcB  = b;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    finish_op(o, a, b, 1, hold);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          ro;
    vectors     = 0;
    miscompares = 0;
    resetN    = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.srcA  = '0;
    bus.srcB  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.divByZero, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_aluA", aluA, 0);
    check("rst_aluCtl", aluControl, 3'b010);
    resetN = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'd3, 32'd5, 1'b0);
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_op(1'b0, 32'h80000000, 32'd2, 1'b0);
    do_op(1'b1, 32'd100, 32'd7, 1'b0);
    do_op(1'b1, 32'hFFFFFFFE, 32'h80000001, 1'b0);
    do_op(1'b1, 32'd5, 32'd9, 1'b0);
    do_op(1'b1, 32'd1234, 32'd0, 1'b0);
    do_op(1'b0, 32'd2, 32'd2, 1'b0);

    // start held high through DONE: accepted only in the first IDLE cycle
    do_op(1'b0, 32'd3, 32'd5, 1'b1);
    @(negedge clk);
    check("restart_busy", bus.busy, 1);
    bus.start = 1'b0;
    finish_op(1'b0, 32'd3, 32'd5, 1, 1'b0);

    // reset in the middle of a divide
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.srcA  = 32'd1000;
    bus.srcB  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 1; t < 10; t++) begin
      check("mid_no_done", bus.done, 0);
      @(negedge clk);
    end
    resetN = 1'b0;
    @(negedge clk);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_hi", bus.hi, 0);
    check("mrst_lo", bus.lo, 0);
    check("mrst_dbz", bus.divByZero, 0);
    resetN = 1'b1;
    @(negedge clk);
    do_op(1'b1, 32'd1000, 32'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
